ex_mem_flag_stage: RTL and testbench
====================================

Name: ex_mem_flag_stage

Overview:
- EX/MEM boundary stage of the 16-bit pipelined WISC CPU; sits directly downstream of the ALU.
- Registers the ALU result and EX control/data into MEM-stage fields.
- Owns the architectural Z/V/N flag register, with per-opcode update enables.
- Evaluates branch condition codes for the ID stage, forwarding same-cycle EX flags.

Parameters:
- DW, 16, datapath width (ALU_Out, store data, PC).
- RW, 4, register specifier width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- EX_valid  in  1  EX holds a real instruction
- EX_Opcode  in  4  EX instruction opcode
- ALU_Out  in  DW  ALU result
- Z_set / V_set / N_set  in  1 each  ALU flag outputs
- EX_rd  in  RW  destination register
- EX_RegWrite / EX_MemRead / EX_MemWrite / EX_HLT  in  1 each  EX control bits
- EX_store_data  in  DW  SW data (already forwarded)
- EX_PC_next  in  DW  PC+2 of EX instruction
- stall  in  1  hold this stage
- flush  in  1  squash EX instruction
- ID_ccc  in  3  condition code of branch in ID
- MEM_valid / MEM_RegWrite / MEM_MemRead / MEM_MemWrite / MEM_HLT  out  1 each  registered
- MEM_ALU_Out / MEM_store_data / MEM_PC_next  out  DW  registered
- MEM_rd  out  RW  registered
- ZF / VF / NF  out  1 each  flag register
- cond_true  out  1  ID branch condition satisfied (combinational)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset state: every MEM_* output is 0 (MEM_valid=0, all data 16'h0000, MEM_rd=0). ZF=VF=NF=0.
- Priority at each clk edge: rst > flush > stall > load.
- flush: MEM register takes a bubble (MEM_valid and all MEM control bits = 0; data fields are don't-care, driven to 0). Flags do not update.
- stall (no flush): all MEM registers and flags hold.
- load: every MEM_* field captures its EX_* counterpart, MEM_valid <= EX_valid. Control bits are ANDed with EX_valid.
- Latency: 1 cycle from EX inputs to MEM outputs.
- Flag write enable: wr = EX_valid & ~stall & ~flush & ~rst.
  - Opcode 0x0, 0x1 (ADD/SUB): Z, V and N all written from Z_set, V_set, N_set.
  - Opcode 0x2, 0x4, 0x5, 0x6 (XOR/SLL/SRA/ROR): Z only; V and N hold.
  - All other opcodes (RED, PADDSB, LW, SW, LLB, LHB, B, BR, PCS, HLT, 0x3, 0x7–0xF): no flag change.
- Effective flags for cond_true:
  - Each flag is taken from the EX set signal when that flag's write enable would fire this cycle, ignoring stall.
  - Otherwise the registered flag is used.
  - Flush suppresses forwarding.
- cond_true by ID_ccc, using effective Z, N, V:
  - 000: ~Z
  - 001: Z
  - 010: ~Z & ~N
  - 011: N
  - 100: Z | (~Z & ~N)
  - 101: N | Z
  - 110: V
  - 111: 1
- After MEM_HLT=1 is captured, the stage keeps loading normally; upstream is responsible for stopping fetch.
- Reset mid-operation: all state returns to reset values on the same edge, including a pending flag write.
- X handling: no X may propagate to MEM_valid or flags when EX_valid=0.

Test Plan:
- Reset: rst=1 for 2 cycles with EX_valid=1, ALU_Out=16'hBEEF -> all MEM_* = 0, ZF=VF=NF=0; after release, the next edge loads 16'hBEEF, MEM_valid=1.
- ADD flags: EX_Opcode=0, Z_set=0, V_set=1, N_set=0, ALU_Out=16'h7FFF -> next cycle VF=1, ZF=0, NF=0, MEM_ALU_Out=16'h7FFF. Then XOR with Z_set=1, N_set=1 -> ZF=1, NF stays 0, VF stays 1.
- Non-flag opcode: flags ZF=1, VF=1, NF=0, then LW (0x8) with Z_set=0, V_set=0, N_set=1 -> flags unchanged; MEM_MemRead=1.
- Forwarding: registered ZF=1; EX holds SUB with Z_set=0, N_set=0; ID_ccc=001 -> cond_true=0 in the same cycle. Assert flush in the same cycle -> cond_true=1 (registered Z); next cycle MEM_valid=0 and ZF stays 1.
- Stall: load ALU_Out=16'h1234, then stall=1 for 3 cycles while the EX inputs change -> MEM_ALU_Out stays 16'h1234 and flags hold. Stall+flush together -> bubble inserted.
- Condition sweep: for each of the 8 Z/N/V combinations with EX_valid=0, step ID_ccc 000–111 -> cond_true matches the table. Case Z=0, N=1, V=1: ccc 000 gives 1, 010 gives 0, 101 gives 1, 110 gives 1.

Source files
------------

// File: rtl/ex_mem_flag_stage.sv
// ex_mem_flag_stage: EX/MEM pipeline register with Z/V/N flag register and branch condition evaluation
module ex_mem_flag_stage #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          EX_valid,
  input  logic [3:0]    EX_Opcode,
  input  logic [DW-1:0] ALU_Out,
  input  logic          Z_set,
  input  logic          V_set,
  input  logic          N_set,
  input  logic [RW-1:0] EX_rd,
  input  logic          EX_RegWrite,
  input  logic          EX_MemRead,
  input  logic          EX_MemWrite,
  input  logic          EX_HLT,
  input  logic [DW-1:0] EX_store_data,
  input  logic [DW-1:0] EX_PC_next,
  input  logic          stall,
  input  logic          flush,
  input  logic [2:0]    ID_ccc,
  output logic          MEM_valid,
  output logic          MEM_RegWrite,
  output logic          MEM_MemRead,
  output logic          MEM_MemWrite,
  output logic          MEM_HLT,
  output logic [DW-1:0] MEM_ALU_Out,
  output logic [DW-1:0] MEM_store_data,
  output logic [DW-1:0] MEM_PC_next,
  output logic [RW-1:0] MEM_rd,
  output logic          ZF,
  output logic          VF,
  output logic          NF,
  output logic          cond_true
);
  logic all_en, z_en, fire, z_fwd, vn_fwd, z_eff, v_eff, n_eff;
  logic [7:0] cc_tbl;
  assign all_en = EX_Opcode == 4'h0 || EX_Opcode == 4'h1;
  assign z_en   = all_en || EX_Opcode == 4'h2 || EX_Opcode == 4'h4 || EX_Opcode == 4'h5 || EX_Opcode == 4'h6;
  // forwarding ignores stall so ID sees the flags EX is about to produce
  assign fire   = EX_valid & ~flush & ~rst;
  assign z_fwd  = fire & z_en;
  assign vn_fwd = fire & all_en;
  assign z_eff  = z_fwd ? Z_set : ZF;
  assign v_eff  = vn_fwd ? V_set : VF;
  assign n_eff  = vn_fwd ? N_set : NF;
  assign cc_tbl = {1'b1, v_eff, n_eff | z_eff, z_eff | (~z_eff & ~n_eff), n_eff, ~z_eff & ~n_eff, z_eff, ~z_eff};
  assign cond_true = cc_tbl[ID_ccc];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      MEM_valid      <= 1'b0;
      MEM_RegWrite   <= 1'b0;
      MEM_MemRead    <= 1'b0;
      MEM_MemWrite   <= 1'b0;
      MEM_HLT        <= 1'b0;
      MEM_ALU_Out    <= '0;
      MEM_store_data <= '0;
      MEM_PC_next    <= '0;
      MEM_rd         <= '0;
    end else if (!stall) begin
      MEM_valid      <= EX_valid;
      MEM_RegWrite   <= EX_RegWrite & EX_valid;
      MEM_MemRead    <= EX_MemRead & EX_valid;
      MEM_MemWrite   <= EX_MemWrite & EX_valid;
      MEM_HLT        <= EX_HLT & EX_valid;
      MEM_ALU_Out    <= ALU_Out;
      MEM_store_data <= EX_store_data;
      MEM_PC_next    <= EX_PC_next;
      MEM_rd         <= EX_rd;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ZF <= 1'b0;
      VF <= 1'b0;
      NF <= 1'b0;
    end else if (!stall) begin
      if (z_fwd) ZF <= Z_set;
      if (vn_fwd) begin
        VF <= V_set;
        NF <= N_set;
      end
    end
  end
endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// tb_ex_mem_flag_stage: directed plus randomized checks against a behavioural model of the EX/MEM stage
module tb_ex_mem_flag_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, EX_valid, Z_set, V_set, N_set, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_HLT, stall, flush;
  logic [3:0] EX_Opcode, EX_rd;
  logic [15:0] ALU_Out, EX_store_data, EX_PC_next;
  logic [2:0] ID_ccc;
  logic MEM_valid, MEM_RegWrite, MEM_MemRead, MEM_MemWrite, MEM_HLT, ZF, VF, NF, cond_true;
  logic [15:0] MEM_ALU_Out, MEM_store_data, MEM_PC_next;
  logic [3:0] MEM_rd;
  ex_mem_flag_stage #(.DW(16), .RW(4)) dut (
    .clk(clk), .rst(rst), .EX_valid(EX_valid), .EX_Opcode(EX_Opcode), .ALU_Out(ALU_Out),
    .Z_set(Z_set), .V_set(V_set), .N_set(N_set), .EX_rd(EX_rd), .EX_RegWrite(EX_RegWrite),
    .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite), .EX_HLT(EX_HLT),
    .EX_store_data(EX_store_data), .EX_PC_next(EX_PC_next), .stall(stall), .flush(flush),
    .ID_ccc(ID_ccc), .MEM_valid(MEM_valid), .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead),
    .MEM_MemWrite(MEM_MemWrite), .MEM_HLT(MEM_HLT), .MEM_ALU_Out(MEM_ALU_Out),
    .MEM_store_data(MEM_store_data), .MEM_PC_next(MEM_PC_next), .MEM_rd(MEM_rd),
    .ZF(ZF), .VF(VF), .NF(NF), .cond_true(cond_true)
  );
  logic m_valid, m_rw, m_mr, m_mw, m_hlt, m_z, m_v, m_n;
  logic [15:0] m_alu, m_sd, m_pc;
  logic [3:0] m_rd;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // 2 = Z,V,N written; 1 = Z only; 0 = no flags
  function automatic int flag_class(input logic [3:0] op);
    if (op <= 4'h1) return 2;
    if (op == 4'h2 || op == 4'h4 || op == 4'h5 || op == 4'h6) return 1;
    return 0;
  endfunction
  function automatic logic ref_cond(input logic [2:0] ccc, input logic z, input logic n, input logic v);
    case (ccc)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction
  task automatic chk_cond;
    int cls;
    logic fwd;
    cls = flag_class(EX_Opcode);
    fwd = EX_valid && !flush && !rst;
    chk("cond_true", cond_true, ref_cond(ID_ccc, (fwd && cls > 0) ? Z_set : m_z,
        (fwd && cls == 2) ? N_set : m_n, (fwd && cls == 2) ? V_set : m_v));
  endtask
  task automatic step;
    int cls;
    #1;
    if (!rst) chk_cond();
    cls = flag_class(EX_Opcode);
    @(posedge clk);
    if (rst || flush) begin
      {m_valid, m_rw, m_mr, m_mw, m_hlt} = '0;
      {m_alu, m_sd, m_pc, m_rd} = '0;
      if (rst) {m_z, m_v, m_n} = '0;
    end else if (!stall) begin
      m_valid = EX_valid;
      m_rw = EX_valid && EX_RegWrite;
      m_mr = EX_valid && EX_MemRead;
      m_mw = EX_valid && EX_MemWrite;
      m_hlt = EX_valid && EX_HLT;
      m_alu = ALU_Out; m_sd = EX_store_data; m_pc = EX_PC_next; m_rd = EX_rd;
      if (EX_valid && cls > 0) m_z = Z_set;
      if (EX_valid && cls == 2) begin m_v = V_set; m_n = N_set; end
    end
    #1;
    chk("MEM_valid", MEM_valid, m_valid);
    chk("MEM_ctrl", {MEM_RegWrite, MEM_MemRead, MEM_MemWrite, MEM_HLT}, {m_rw, m_mr, m_mw, m_hlt});
    chk("MEM_ALU_Out", MEM_ALU_Out, m_alu);
    chk("MEM_store_data", MEM_store_data, m_sd);
    chk("MEM_PC_next", MEM_PC_next, m_pc);
    chk("MEM_rd", MEM_rd, m_rd);
    chk("flags", {ZF, VF, NF}, {m_z, m_v, m_n});
  endtask
  task automatic rand_ex;
    EX_valid = $urandom_range(0, 3) != 0;
    EX_Opcode = 4'($urandom);
    ALU_Out = 16'($urandom); EX_store_data = 16'($urandom); EX_PC_next = 16'($urandom);
    EX_rd = 4'($urandom);
    {Z_set, V_set, N_set, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_HLT} = 7'($urandom);
    ID_ccc = 3'($urandom);
  endtask
  task automatic set_op(input logic [3:0] op, input logic z, input logic v, input logic n, input logic [15:0] alu);
    EX_valid = 1'b1; EX_Opcode = op; Z_set = z; V_set = v; N_set = n; ALU_Out = alu;
  endtask
  initial begin
    {m_valid, m_rw, m_mr, m_mw, m_hlt, m_z, m_v, m_n} = '0;
    {m_alu, m_sd, m_pc, m_rd} = '0;
    {stall, flush, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_HLT} = '0;
    EX_store_data = 16'h0; EX_PC_next = 16'h0; EX_rd = 4'h0; ID_ccc = 3'd0;
    rst = 1'b1;
    set_op(4'h0, 1'b0, 1'b0, 1'b0, 16'hBEEF);
    step(); step();
    chk("rst_alu", MEM_ALU_Out, 16'h0);
    chk("rst_valid", MEM_valid, 1'b0);
    rst = 1'b0;
    step();
    chk("post_rst_alu", MEM_ALU_Out, 16'hBEEF);
    chk("post_rst_valid", MEM_valid, 1'b1);
    set_op(4'h0, 1'b0, 1'b1, 1'b0, 16'h7FFF);
    step();
    chk("add_flags", {ZF, VF, NF}, 3'b010);
    chk("add_alu", MEM_ALU_Out, 16'h7FFF);
    set_op(4'h2, 1'b1, 1'b0, 1'b1, 16'h0000);
    step();
    chk("xor_flags", {ZF, VF, NF}, 3'b110);
    set_op(4'h8, 1'b0, 1'b0, 1'b1, 16'h0040);
    EX_MemRead = 1'b1; EX_RegWrite = 1'b1;
    step();
    chk("lw_flags", {ZF, VF, NF}, 3'b110);
    chk("lw_memread", MEM_MemRead, 1'b1);
    EX_MemRead = 1'b0; EX_RegWrite = 1'b0;
    set_op(4'h1, 1'b0, 1'b0, 1'b0, 16'h0005);
    ID_ccc = 3'b001;
    #1 chk("fwd_cond", cond_true, 1'b0);
    flush = 1'b1;
    #1 chk("flush_cond", cond_true, 1'b1);
    step();
    chk("flush_valid", MEM_valid, 1'b0);
    chk("flush_zf", ZF, 1'b1);
    flush = 1'b0;
    set_op(4'h0, 1'b0, 1'b0, 1'b0, 16'h1234);
    EX_Opcode = 4'h9;
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_ex();
      step();
      chk("stall_alu", MEM_ALU_Out, 16'h1234);
    end
    EX_valid = 1'b1;
    flush = 1'b1;
    step();
    chk("stall_flush_valid", MEM_valid, 1'b0);
    {stall, flush} = 2'b00;
    for (int c = 0; c < 8; c++) begin
      logic [2:0] zvn;
      zvn = 3'(c);
      set_op(4'h0, zvn[2], zvn[1], zvn[0], 16'h0);
      step();
      EX_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
        ID_ccc = 3'(k);
        #1 chk("sweep_cond", cond_true, ref_cond(ID_ccc, zvn[2], zvn[0], zvn[1]));
        if (zvn == 3'b011 && k == 0) chk("znv011_ccc0", cond_true, 1'b1);
        if (zvn == 3'b011 && k == 2) chk("znv011_ccc2", cond_true, 1'b0);
        if (zvn == 3'b011 && k == 5) chk("znv011_ccc5", cond_true, 1'b1);
        if (zvn == 3'b011 && k == 6) chk("znv011_ccc6", cond_true, 1'b1);
      end
    end
    for (int i = 0; i < 3000; i++) begin
      rand_ex();
      stall = $urandom_range(0, 4) == 0;
      flush = $urandom_range(0, 7) == 0;
      rst = $urandom_range(0, 63) == 0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
